fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage upstream of decode/ControlUnit. Owns the PC, drives a synchronous
//  1-cycle-latency instruction memory, buffers returned words in a 2-entry queue, and hands
//  {instr, pc, pc+4} to decode over valid/ready. Redirects from branch/jump resolution win.
// PARAMETERS
//  ADDR_W    8             PC/byte-address width; PC wraps modulo 2**ADDR_W
//  DATA_W    32            instruction width
//  RESET_PC  {ADDR_W{1'b0}} PC value loaded on reset
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       asynchronous, active-high reset
//  redirect_valid  in   1       load redirect_target into PC, flush queue and in-flight fetch
//  redirect_target in   ADDR_W  new PC; bits [1:0] ignored (forced 0)
//  halt_req        in   1       stop issuing fetches after the current cycle
//  imem_en         out  1       fetch request this cycle
//  imem_addr       out  ADDR_W  fetch address (= PC)
//  imem_rdata      in   DATA_W  instruction, valid the cycle after imem_en
//  out_valid       out  1       queue head valid
//  out_ready       in   1       decode accepts head when out_valid && out_ready
//  out_instr       out  DATA_W  head instruction
//  out_pc          out  ADDR_W  head PC
//  out_pc4         out  ADDR_W  head PC+4 (mod 2**ADDR_W)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=BOOT, queue empty, inflight=0; imem_en=0, out_valid=0,
//    out_instr/out_pc/out_pc4=0. Reset mid-operation discards everything, no partial pop.
//  - FSM: BOOT -(1 cycle)-> RUN; RUN -(halt_req && !redirect_valid)-> HALT;
//    HALT -(redirect_valid)-> RUN; any state -(reset)-> BOOT. No fetch issued in BOOT/HALT.
//  - Issue (RUN only): imem_en=1 when count - pop + inflight < 2, pop = out_valid&&out_ready;
//    on issue pc<=pc+4 (wraps 0xFC->0x00 at ADDR_W=8), inflight<=1 next cycle.
//  - Response: cycle after issue, {imem_rdata, issued pc, pc+4} pushed to queue tail.
//    Push and pop in the same cycle allowed; queue never overflows (credit rule above).
//  - Latency: reset release -> first out_valid = 3 cycles (BOOT, issue, push). Sustained
//    throughput 1 instr/cycle while out_ready=1.
//  - Redirect (priority over halt, pop, push): pc<=redirect_target&~3; queue cleared;
//    in-flight response of this or the previous cycle dropped; out_valid=0 next cycle;
//    imem_en=0 in the redirect cycle; fetch from target the following cycle (state=RUN).
//    Pop in the redirect cycle still counts as consumed by decode.
//  - out_ready=0: head held stable; issue stops once count+inflight reaches 2.
//  - HALT: in-flight response still pushed; queue drains normally.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetch_cnt[31:0] (+1 per push) and
//    perf_stall_cnt[31:0] (+1 per cycle out_valid && !out_ready); both reset to 0, wrap.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared header fetch_defs.vh: FSM encodings (ST_BOOT/ST_RUN/ST_HALT), NOP word 32'h0,
//    default RESET_PC, PC increment constant 4.
//  Sub-module fetch_queue: 2-entry FIFO of {instr,pc,pc4} with push/pop/flush, count out.
// TESTING
//  1 reset, out_ready=1, imem word=addr -> out_valid at cycle 3; out_pc 0x00,0x04,0x08 back-to-back.
//  2 out_ready low 5 cycles after first valid -> head stable, imem_en drops at count+inflight=2,
//    no lost/duplicated instr after ready rises.
//  3 redirect_valid with target 0x43 while queue full + inflight -> next out_pc=0x40,
//    no stale word ever presented.
//  4 pc at 0xFC, run -> imem_addr 0xFC then 0x00; out_pc4 of 0xFC = 0x00.
//  5 halt_req in RUN -> no further imem_en, queue drains; redirect 0x10 -> fetch resumes at 0x10.
//  6 reset asserted mid-stream (async, between edges) -> outputs 0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Purpose: shared FSM encodings and fetch constants for fetch_stage and its queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Presented on out_instr whenever the queue is empty.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Default PC after reset; widened to ADDR_W at the point of use.
    localparam int DEFAULT_RESET_PC = 0;

    // Byte distance between consecutive instructions.
    localparam int PC_INC = 4;

endpackage

// File: rtl/fetch_stage_queue.sv
// Purpose: 2-entry FIFO with flush, holding packed {instr, pc, pc4} fetch entries.
// Latency: push visible at head the cycle after push; head is combinational from storage.
// Backpressure: none internal; caller guarantees no push when full (credit-limited upstream).
//
// Ports: clk, reset (async active-high), flush (clears contents, beats push/pop),
//        in_vld/in_dat (push), pop_en (drop head), head_vld/head_dat, count (0..2).
module fetch_stage_queue #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    input  logic             pop_en,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_pop;

    // Popping an empty queue is ignored rather than underflowing the count.
    assign do_pop   = pop_en && (count_q != 2'd0);
    assign head_vld = (count_q != 2'd0);
    assign head_dat = slot_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (in_vld) begin
                slot_q[wr_ptr_q] <= in_dat;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, in_vld} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Purpose: instruction fetch; owns PC, drives 1-cycle imem, queues words for decode.
// Latency: reset release -> first out_valid in 3 cycles; 1 instr/cycle sustained.
// Backpressure: out_ready low holds head; issue stops once queued + in-flight reaches 2.
//
// Ports: clk, reset (async active-high); redirect_valid/redirect_target (flush + new PC);
//        halt_req; imem_en/imem_addr/imem_rdata (synchronous imem, data one cycle later);
//        out_valid/out_ready/out_instr/out_pc/out_pc4 (decode handoff).
// Optional: FETCH_PERF_EN adds perf_fetch_cnt (pushes) and perf_stall_cnt (stalled cycles).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt_req,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int ENT_W = DATA_W + 2 * ADDR_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              fetch_en;
    logic              pop;
    logic              push;
    logic              q_vld;
    logic [1:0]        q_count;
    logic [ENT_W-1:0]  push_dat;
    logic [ENT_W-1:0]  head_dat;
    logic [2:0]        occupancy;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (!redirect_valid && halt_req) state_d = ST_HALT;
            ST_HALT: if (redirect_valid) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A slot is free when what is queued plus what is still coming back, less
    // what decode takes this cycle, leaves room; this is what keeps the
    // 2-entry queue from ever overflowing.
    assign pop       = q_vld && out_ready;
    assign occupancy = {1'b0, q_count} + {2'b00, inflight_q};

    always_comb begin
        fetch_en = 1'b0;
        if (state_q == ST_RUN && !redirect_valid &&
            occupancy < (3'd2 + {2'b00, pop})) begin
            fetch_en = 1'b1;
        end
    end

    assign imem_en   = fetch_en;
    assign imem_addr = pc_q;

    // ---------------- PC and in-flight tracking ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= fetch_en;
            if (fetch_en) begin
                inflight_pc_q <= pc_q;
            end
            if (redirect_valid) begin
                pc_q <= redirect_target & ~ADDR_W'(3);
            end else if (fetch_en) begin
                pc_q <= pc_q + ADDR_W'(PC_INC);
            end
        end
    end

    // A response landing in a redirect cycle belongs to the old path: drop it.
    assign push     = inflight_q && !redirect_valid;
    assign push_dat = {imem_rdata, inflight_pc_q, inflight_pc_q + ADDR_W'(PC_INC)};

    fetch_stage_queue #(
        .WIDTH(ENT_W)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .in_vld   (push),
        .in_dat   (push_dat),
        .pop_en   (pop),
        .head_vld (q_vld),
        .head_dat (head_dat),
        .count    (q_count)
    );

    // Empty queue presents a NOP with zero PCs so no stale entry is ever visible.
    assign out_valid = q_vld;
    assign out_instr = q_vld ? head_dat[ENT_W-1 -: DATA_W]        : DATA_W'(NOP_WORD);
    assign out_pc    = q_vld ? head_dat[2*ADDR_W-1 -: ADDR_W]     : '0;
    assign out_pc4   = q_vld ? head_dat[ADDR_W-1:0]               : '0;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (q_vld && !out_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: directed self-checking bench for fetch_stage (boot, stall, redirect, wrap, halt, reset).
// Latency: n/a.
// Backpressure: out_ready driven per vector.
module tb_fetch_stage;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              halt_req;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata = '0;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc4;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_fetch_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (8'h00)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .imem_en         (imem_en),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc4         (out_pc4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    // Instruction memory contents: a tag plus the byte address, so any word
    // identifies where it was fetched from.
    function automatic logic [31:0] word_of(input logic [7:0] a);
        return 32'hC0DE_0000 | {24'h0, a};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= word_of(imem_addr);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whatever the head shows must be the word stored at its own PC.
    always @(negedge clk) begin
        if (!reset && out_valid) check_val("head_word", out_instr, word_of(out_pc));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic vld, input logic [7:0] pc);
        check_val({tag, "_vld"}, 32'(out_valid), 32'(vld));
        if (vld) check_val({tag, "_pc"}, 32'(out_pc), 32'(pc));
    endtask

    task automatic chk_fetch(input string tag, input logic en, input logic [7:0] addr);
        check_val({tag, "_en"}, 32'(imem_en), 32'(en));
        if (en) check_val({tag, "_addr"}, 32'(imem_addr), 32'(addr));
    endtask

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        halt_req        = 1'b0;
        out_ready       = 1'b1;

        // ---- reset state ----
        #12;
        check_val("rst_en",    32'(imem_en),   32'd0);
        check_val("rst_vld",   32'(out_valid), 32'd0);
        check_val("rst_instr", out_instr,      32'd0);
        check_val("rst_pc",    32'(out_pc),    32'd0);
        check_val("rst_pc4",   32'(out_pc4),   32'd0);

        // ---- 1: boot latency and back-to-back delivery ----
        step(); reset = 1'b0; #1;                   // c0 BOOT
        chk_fetch("c0", 1'b0, 8'h00);
        step(); chk_fetch("c1", 1'b1, 8'h00); chk_head("c1", 1'b0, 8'h00);
        step(); chk_fetch("c2", 1'b1, 8'h04); chk_head("c2", 1'b0, 8'h00);
        step(); chk_head("c3", 1'b1, 8'h00);
        check_val("c3_pc4", 32'(out_pc4), 32'h04);
        check_val("c3_instr", out_instr, 32'hC0DE_0000);
        step(); chk_head("c4", 1'b1, 8'h04);

        // ---- 2: decode stalls 5 cycles ----
        step(); out_ready = 1'b0; #1;               // c5: queued 1 + in-flight 1
        chk_head("c5", 1'b1, 8'h08); chk_fetch("c5", 1'b0, 8'h00);
        for (int i = 6; i <= 9; i++) begin
            step();
            chk_head("stall", 1'b1, 8'h08);
            chk_fetch("stall", 1'b0, 8'h00);
        end
        step(); out_ready = 1'b1; #1;               // c10
        chk_head("c10", 1'b1, 8'h08); chk_fetch("c10", 1'b1, 8'h10);
        step(); chk_head("c11", 1'b1, 8'h0C);
        step(); chk_head("c12", 1'b1, 8'h10);
        step(); chk_head("c13", 1'b1, 8'h14);

        // ---- 3: redirect to 0x43 with a response in flight ----
        step(); redirect_valid = 1'b1; redirect_target = 8'h43; #1;   // c14
        chk_head("c14", 1'b1, 8'h18); chk_fetch("c14", 1'b0, 8'h00);
        step(); redirect_valid = 1'b0; #1;
        chk_head("c15", 1'b0, 8'h00); chk_fetch("c15", 1'b1, 8'h40);
        step(); chk_head("c16", 1'b0, 8'h00); chk_fetch("c16", 1'b1, 8'h44);
        step(); chk_head("c17", 1'b1, 8'h40);
        check_val("c17_pc4", 32'(out_pc4), 32'h44);

        // ---- 4: PC wrap at 0xFC ----
        redirect_valid = 1'b1; redirect_target = 8'hFC; #1;
        chk_fetch("c17r", 1'b0, 8'h00);
        step(); redirect_valid = 1'b0; #1;
        chk_fetch("c18", 1'b1, 8'hFC); chk_head("c18", 1'b0, 8'h00);
        step(); chk_fetch("c19", 1'b1, 8'h00);
        step(); chk_head("c20", 1'b1, 8'hFC);
        check_val("wrap_pc4", 32'(out_pc4), 32'h00);
        step(); chk_head("c21", 1'b1, 8'h00);
        check_val("c21_pc4", 32'(out_pc4), 32'h04);

        // ---- 5: halt, drain, resume via redirect ----
        halt_req = 1'b1; #1;
        chk_fetch("c21h", 1'b1, 8'h08);
        step(); halt_req = 1'b0; #1;
        chk_fetch("c22", 1'b0, 8'h00); chk_head("c22", 1'b1, 8'h04);
        step(); chk_fetch("c23", 1'b0, 8'h00); chk_head("c23", 1'b1, 8'h08);
        step(); chk_fetch("c24", 1'b0, 8'h00); chk_head("c24", 1'b0, 8'h00);
        step(); redirect_valid = 1'b1; redirect_target = 8'h10; #1;
        chk_fetch("c25", 1'b0, 8'h00);
        step(); redirect_valid = 1'b0; #1;
        chk_fetch("c26", 1'b1, 8'h10);
        step(); chk_fetch("c27", 1'b1, 8'h14); chk_head("c27", 1'b0, 8'h00);
        step(); chk_head("c28", 1'b1, 8'h10);

        // ---- 6: asynchronous reset between edges ----
        step(); #2; reset = 1'b1; #1;
        check_val("arst_en",    32'(imem_en),   32'd0);
        check_val("arst_vld",   32'(out_valid), 32'd0);
        check_val("arst_instr", out_instr,      32'd0);
        check_val("arst_pc",    32'(out_pc),    32'd0);
        check_val("arst_pc4",   32'(out_pc4),   32'd0);
        check_val("arst_addr",  32'(imem_addr), 32'd0);
        step(); step(); reset = 1'b0; #1;
        chk_fetch("r0", 1'b0, 8'h00);
        step(); chk_fetch("r1", 1'b1, 8'h00);
        step(); chk_fetch("r2", 1'b1, 8'h04); chk_head("r2", 1'b0, 8'h00);
        step(); chk_head("r3", 1'b1, 8'h00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
